// File: rtl/tx_fifo_reader_if.sv
// Handshake bundle between the TX FIFO read port, the reader engine and the DS character encoder.
// The master side is the reader engine. The slave side is the FIFO plus encoder environment.
interface tx_fifo_reader_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
);
  logic [AW:0]   fifo_fill_level;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_r_en;
  logic          char_valid;
  logic [DW-1:0] char_data;
  logic          char_ready;

  modport master (
    input  fifo_fill_level, fifo_r_data, char_ready,
    output fifo_r_en, char_valid, char_data
  );

  modport slave (
    output fifo_fill_level, fifo_r_data, char_ready,
    input  fifo_r_en, char_valid, char_data
  );
endinterface

// File: rtl/tx_fifo_reader.sv
// IEEE1355 TX read engine: pops the TX FIFO under FCT credit control.
// Each popped byte is presented to the DS encoder on a valid/ready stream.
module tx_fifo_reader #(
  parameter int unsigned G_DATA_WIDTH_BITS = 8,
  parameter int unsigned G_ADDR_WIDTH_BITS = 6,
  parameter int unsigned G_CREDIT_PER_FCT  = 8,
  parameter int unsigned G_MAX_CREDIT      = 56,
  localparam int unsigned CW = $clog2(G_MAX_CREDIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tx_fifo_reader_if.master      bus,
  input  logic                  fct_rcvd,
  output logic [CW-1:0]         credit,
  output logic                  credit_err,
  output logic [15:0]           chars_sent
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                       state, state_nxt;
  logic                         can_pop;
  logic [G_DATA_WIDTH_BITS-1:0] char_data_nxt;
  logic [CW:0]                  credit_sum;
  logic [CW-1:0]                credit_nxt;
  logic                         err_nxt;

  // A pop needs data and credit, and the held char (if any) must be leaving this cycle.
  always_comb begin
    can_pop = (bus.fifo_fill_level != '0) && (credit != '0) &&
              ((state == IDLE) || bus.char_ready);
  end

  // fifo_r_en is combinational so that the FIFO pops in the same cycle the byte is captured.
  assign bus.fifo_r_en = can_pop && rst_n;

  // Credit update is computed one bit wider, so that an overflowing FCT can be detected.
  always_comb begin
    credit_sum = {1'b0, credit} - (CW+1)'(can_pop) +
                 (fct_rcvd ? (CW+1)'(G_CREDIT_PER_FCT) : (CW+1)'(0));
    credit_nxt = credit_sum[CW-1:0];
    err_nxt    = 1'b0;
    if (fct_rcvd && (credit_sum > (CW+1)'(G_MAX_CREDIT))) begin
      credit_nxt = credit - CW'(can_pop);
      err_nxt    = 1'b1;
    end
  end

  // Next-state logic for the stream FSM.
  always_comb begin
    state_nxt     = state;
    char_data_nxt = bus.char_data;
    case (state)
      IDLE: begin
        if (can_pop) begin
          char_data_nxt = bus.fifo_r_data;
          state_nxt     = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.char_ready) begin
          if (can_pop) char_data_nxt = bus.fifo_r_data;
          else         state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.char_valid <= 1'b0;
      bus.char_data  <= '0;
      credit         <= '0;
      credit_err     <= 1'b0;
      chars_sent     <= '0;
    end else begin
      state          <= state_nxt;
      bus.char_valid <= (state_nxt == PRESENT);
      bus.char_data  <= char_data_nxt;
      credit         <= credit_nxt;
      credit_err     <= credit_err | err_nxt;
      if (bus.char_valid && bus.char_ready) chars_sent <= chars_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_fifo_reader.sv
// Bench for tx_fifo_reader: a FIFO model with a scoreboard of expected chars.
// It also applies a credit vector table and some multi-cycle handshake sequences.
module tb_tx_fifo_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fct_rcvd;
  logic [CW-1:0] credit;
  logic          credit_err;
  logic [15:0]   chars_sent;

  always #5 clk = ~clk;

  tx_fifo_reader_if #(.DW(DW), .AW(AW)) bus();

  tx_fifo_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fct_rcvd   (fct_rcvd),
    .credit     (credit),
    .credit_err (credit_err),
    .chars_sent (chars_sent)
  );

  // The FIFO model's fill level drops one clock after the pop strobe.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  assign bus.fifo_fill_level = 7'(wr_ptr - rd_ptr);
  assign bus.fifo_r_data     = mem[rd_ptr];

  always @(posedge clk) if (bus.fifo_r_en) rd_ptr <= rd_ptr + 8'd1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic          fct;
    logic [CW-1:0] exp_credit;
    logic          exp_err;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(b);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted char must be the next expected byte. A held char must never be popped over.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.char_valid && bus.char_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got char %0h, expected none", bus.char_data);
        end else begin
          chk("sb_data", 32'(bus.char_data), 32'(exp_q.pop_front()));
        end
      end
      if (bus.char_valid && !bus.char_ready) chk("hold_no_pop", 32'(bus.fifo_r_en), 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    vecs[0] = '{1'b1, 6'd8,  1'b0};
    vecs[1] = '{1'b1, 6'd16, 1'b0};
    vecs[2] = '{1'b1, 6'd24, 1'b0};
    vecs[3] = '{1'b1, 6'd32, 1'b0};
    vecs[4] = '{1'b1, 6'd40, 1'b0};
    vecs[5] = '{1'b1, 6'd48, 1'b0};
    vecs[6] = '{1'b1, 6'd56, 1'b0};
    vecs[7] = '{1'b1, 6'd56, 1'b1};
    vecs[8] = '{1'b0, 6'd56, 1'b1};

    // Reset holds everything off, even with data present and FCTs arriving.
    rst_n = 1'b0; fct_rcvd = 1'b1; bus.char_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1));
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_r_en",   32'(bus.fifo_r_en),  32'd0);
      chk("rst_valid",  32'(bus.char_valid), 32'd0);
      chk("rst_credit", 32'(credit),         32'd0);
      chk("rst_err",    32'(credit_err),     32'd0);
    end
    chk("rst_sent", 32'(chars_sent), 32'd0);
    fct_rcvd = 1'b0;
    flush();

    // With no credit, nothing is popped.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      chk("nocred_r_en", 32'(bus.fifo_r_en), 32'd0);
      step(1);
    end
    chk("nocred_valid",  32'(bus.char_valid), 32'd0);
    chk("nocred_credit", 32'(credit),         32'd0);
    flush();

    // One FCT allows exactly 8 back-to-back pops.
    for (int i = 0; i < 10; i++) push_byte(8'(i));
    bus.char_ready = 1'b1;
    fct_rcvd = 1'b1;
    step(1);
    fct_rcvd = 1'b0;
    chk("fct_credit", 32'(credit), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("stream_r_en", 32'(bus.fifo_r_en), 32'd1);
      step(1);
    end
    chk("stream_stop_r_en", 32'(bus.fifo_r_en), 32'd0);
    step(1);
    chk("stream_valid", 32'(bus.char_valid),      32'd0);
    chk("stream_credit", 32'(credit),             32'd0);
    chk("stream_sent",  32'(chars_sent),          32'd8);
    chk("stream_fill",  32'(bus.fifo_fill_level), 32'd2);
    flush();

    // Backpressure: the held char stays stable, and the next byte follows once ready returns.
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    bus.char_ready = 1'b0;
    fct_rcvd = 1'b1;
    step(1);
    fct_rcvd = 1'b0;
    chk("bp_first_pop", 32'(bus.fifo_r_en), 32'd1);
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.char_valid), 32'd1);
      chk("bp_data",  32'(bus.char_data),  32'hA0);
      chk("bp_r_en",  32'(bus.fifo_r_en),  32'd0);
      step(1);
    end
    bus.char_ready = 1'b1;
    #1;
    chk("bp_resume_pop", 32'(bus.fifo_r_en), 32'd1);
    step(1);
    chk("bp_next_valid", 32'(bus.char_valid), 32'd1);
    chk("bp_next_data",  32'(bus.char_data),  32'hA1);
    step(3);
    chk("bp_end_valid",  32'(bus.char_valid), 32'd0);
    chk("bp_end_credit", 32'(credit),         32'd4);
    chk("bp_end_sent",   32'(chars_sent),     32'd12);

    // Credit saturation vectors with an empty FIFO.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    flush();
    chk("ovf_start_credit", 32'(credit),     32'd0);
    chk("ovf_start_sent",   32'(chars_sent), 32'd0);
    for (int i = 0; i < 9; i++) begin
      fct_rcvd = vecs[i].fct;
      step(1);
      chk("ovf_credit", 32'(credit),     32'(vecs[i].exp_credit));
      chk("ovf_err",    32'(credit_err), 32'(vecs[i].exp_err));
    end
    fct_rcvd = 1'b0;

    // Credit=1 with an FCT on the pop cycle: both apply, and streaming continues.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    flush();
    bus.char_ready = 1'b1;
    for (int i = 0; i < 7; i++) push_byte(8'(8'h10 + i));
    fct_rcvd = 1'b1;
    step(1);
    fct_rcvd = 1'b0;
    step(10);
    chk("c1_credit", 32'(credit),         32'd1);
    chk("c1_valid",  32'(bus.char_valid), 32'd0);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h20 + i));
    fct_rcvd = 1'b1;
    #1;
    chk("c1_pop", 32'(bus.fifo_r_en), 32'd1);
    step(1);
    fct_rcvd = 1'b0;
    chk("c1_credit_after", 32'(credit),        32'd8);
    chk("c1_stream_pop",   32'(bus.fifo_r_en), 32'd1);
    step(3);
    chk("c1_end_valid",  32'(bus.char_valid), 32'd0);
    chk("c1_end_credit", 32'(credit),         32'd6);
    chk("c1_end_sent",   32'(chars_sent),     32'd10);
    chk("c1_end_err",    32'(credit_err),     32'd0);
    chk("sb_drained",    32'(exp_q.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
